// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter feeding the receiver's rx_serial line.
// Each byte is framed as start(0), 8 data bits LSB-first, parity, stop(1).
// The parity bit is the XOR of the data bits, so data plus parity has even
// parity. A one-deep holding register lets the producer queue the next byte
// while the current frame shifts out, so back-to-back frames have no gap.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   tx_byte    byte to send, taken when tx_valid && tx_ready
//   tx_valid   producer has a byte on tx_byte
//   tx_ready   holding register empty (registered)
//   tx_serial  serial line, idle high, driven straight from a flop
//   tx_busy    high while a frame is in START/DATA/PARITY/STOP
//   tx_done    one-cycle pulse on the last cycle of each stop bit
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high, waiting for the holding register to fill
// START  | start bit (0) for Clkperbaud cycles
// DATA   | data bits shift[0..7], Clkperbaud cycles each
// PARITY | XOR of the data bits for Clkperbaud cycles
// STOP   | stop bit (1); reloads directly into START if a byte is queued
`timescale 1ns/1ps

module uart_tx #(
  parameter int Clkperbaud = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int              CntW    = (Clkperbaud > 1) ? $clog2(Clkperbaud) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Clkperbaud - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CntW-1:0] r_clk_count;
  logic [2:0]      r_bit_index;
  logic [7:0]      r_hold;
  logic [7:0]      r_shift;
  logic            r_hold_full;
  logic            r_ready;
  logic            r_parity;
  logic            r_serial;

  logic            w_bit_end;
  logic            w_load;
  logic            w_accept;
  logic            w_hold_full_next;
  logic            w_serial_next;
  logic            w_busy;
  logic            w_done;

  assign w_bit_end = (r_clk_count == CntLast);
  assign w_accept  = tx_valid && r_ready;

  // A frame start and an accept can never coincide: a frame only starts
  // while the hold register is full, and then tx_ready is already low.
  assign w_hold_full_next = w_load ? 1'b0 : (w_accept ? 1'b1 : r_hold_full);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; w_load marks the cycle the hold register moves to shift
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_state_next = S_START;
          w_load       = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_bit_index == 3'd7)) w_state_next = S_PARITY;
      end
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_hold_full) begin
            w_state_next = S_START;
            w_load       = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode; the line value is registered below, one cycle behind state
  always_comb begin
    w_busy        = (r_state != S_IDLE);
    w_done        = (r_state == S_STOP) && w_bit_end;
    w_serial_next = 1'b1;
    case (r_state)
      S_IDLE:   w_serial_next = 1'b1;
      S_START:  w_serial_next = 1'b0;
      S_DATA:   w_serial_next = r_shift[r_bit_index];
      S_PARITY: w_serial_next = r_parity;
      S_STOP:   w_serial_next = 1'b1;
      default:  w_serial_next = 1'b1;
    endcase
  end

  // Datapath: hold/shift registers, counters, line flop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
      r_shift     <= 8'h00;
      r_parity    <= 1'b0;
      r_clk_count <= '0;
      r_bit_index <= 3'd0;
      r_serial    <= 1'b1;
    end else begin
      if (w_accept) begin
        r_hold <= tx_byte;
      end
      r_hold_full <= w_hold_full_next;
      r_ready     <= !w_hold_full_next;

      if (w_load) begin
        r_shift  <= r_hold;
        r_parity <= ^r_hold;
      end

      if ((r_state == S_IDLE) || w_bit_end) begin
        r_clk_count <= '0;
      end else begin
        r_clk_count <= r_clk_count + CntOne;
      end

      // Held at 0 outside DATA so every DATA phase begins at bit 0
      if (r_state != S_DATA) begin
        r_bit_index <= 3'd0;
      end else if (w_bit_end) begin
        r_bit_index <= r_bit_index + 3'd1;
      end

      r_serial <= w_serial_next;
    end
  end

  assign tx_ready  = r_ready;
  assign tx_serial = r_serial;
  assign tx_busy   = w_busy;
  assign tx_done   = w_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx with Clkperbaud = 16.
// A negedge monitor decodes the line into 11-bit frames
// {stop, parity, data[7:0], start}, records tx_done pulses by their position
// within the busy run, and records busy run lengths. Stimulus is driven
// 1 ns after each rising edge.
`timescale 1ns/1ps

module tb_uart_tx;

  localparam int Cpb = 16;

  logic       clk;
  logic       rst;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx #(.Clkperbaud(Cpb)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  int frame_q[$];
  int start_q[$];
  int acc_q[$];
  int done_ord_q[$];
  int busy_run_q[$];
  int n_low;
  int n_done;
  int n_busy;
  int n_notready;
  int busy_run = 0;
  bit rx_active = 1'b0;
  int rx_start;
  int rx_frame;

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
      busy_run  = 0;
    end else begin
      if (!tx_serial) n_low++;
      if (!tx_ready) n_notready++;
      if (tx_busy) begin
        busy_run++;
        n_busy++;
      end else if (busy_run != 0) begin
        busy_run_q.push_back(busy_run);
        busy_run = 0;
      end
      if (tx_done) begin
        n_done++;
        done_ord_q.push_back(busy_run);
      end
      if (tx_valid && tx_ready) acc_q.push_back(cyc + 1);
      if (!rx_active) begin
        if (!tx_serial) begin
          rx_active = 1'b1;
          rx_start  = cyc;
          rx_frame  = 0;
        end
      end else begin
        int off;
        off = cyc - rx_start;
        if (off >= 8 && ((off - 8) % Cpb) == 0) begin
          int idx;
          idx = (off - 8) / Cpb;
          rx_frame[idx] = tx_serial;
          if (idx == 10) begin
            frame_q.push_back(rx_frame);
            start_q.push_back(rx_start);
            rx_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_mon();
    frame_q.delete();
    start_q.delete();
    acc_q.delete();
    done_ord_q.delete();
    busy_run_q.delete();
    n_low      = 0;
    n_done     = 0;
    n_busy     = 0;
    n_notready = 0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frame_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("frame_count", frame_q.size(), n);
  endtask

  // Offer one byte while idle; accepted on the next edge
  task automatic send_one(input logic [7:0] b);
    tx_byte  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Hold tx_valid with b until tx_ready, then drop it after the accepting edge
  task automatic offer_held(input logic [7:0] b);
    int k = 0;
    tx_byte  = b;
    tx_valid = 1'b1;
    while (!tx_ready && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    tx_byte  = 8'h00;
    tx_valid = 1'b0;
    clear_mon();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_serial", tx_serial, 1);
    chk("rst_ready",  tx_ready,  1);
    chk("rst_busy",   tx_busy,   0);
    chk("rst_done",   tx_done,   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();

    // Idle 50 cycles
    repeat (50) @(posedge clk);
    #1;
    chk("idle_low",      n_low,      0);
    chk("idle_done",     n_done,     0);
    chk("idle_busy",     n_busy,     0);
    chk("idle_notready", n_notready, 0);

    // 0x41: two ones, parity 0
    clear_mon();
    send_one(8'h41);
    wait_frames(1, 300);
    chk("f41_frame",    qat(frame_q, 0), 11'b1_0_01000001_0);
    chk("f41_latency",  qat(start_q, 0) - qat(acc_q, 0), 2);
    chk("f41_ndone",    n_done, 1);
    chk("f41_done_pos", qat(done_ord_q, 0), 176);
    chk("f41_busy_len", qat(busy_run_q, 0), 176);
    chk("f41_idle_line", tx_serial, 1);

    // 0x07: three ones, parity 1
    clear_mon();
    send_one(8'h07);
    wait_frames(1, 300);
    chk("f07_frame",    qat(frame_q, 0), 11'b1_1_00000111_0);
    chk("f07_ndone",    n_done, 1);
    chk("f07_busy_len", qat(busy_run_q, 0), 176);

    // 0xA5 then 0x3C queued during the first frame
    clear_mon();
    tx_byte  = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    offer_held(8'h3C);
    wait_frames(2, 600);
    chk("b2b_frame0",   qat(frame_q, 0), 11'b1_0_10100101_0);
    chk("b2b_frame1",   qat(frame_q, 1), 11'b1_0_00111100_0);
    chk("b2b_gap",      qat(start_q, 1) - qat(start_q, 0), 176);
    chk("b2b_busy_len", qat(busy_run_q, 0), 352);
    chk("b2b_nruns",    busy_run_q.size(), 1);
    chk("b2b_ndone",    n_done, 2);
    chk("b2b_done0",    qat(done_ord_q, 0), 176);
    chk("b2b_done1",    qat(done_ord_q, 1), 352);

    // Reset during DATA bit 3 of 0xFF with 0x55 queued
    clear_mon();
    tx_byte  = 8'hFF;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    offer_held(8'h55);
    repeat (68) @(posedge clk);
    @(negedge clk);
    chk("rmid_busy",     tx_busy,  1);
    chk("rmid_queued",   tx_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    @(negedge clk);
    chk("rmid_serial",   tx_serial, 1);
    chk("rmid_ready",    tx_ready,  1);
    chk("rmid_busy_off", tx_busy,   0);
    repeat (400) @(posedge clk);
    #1;
    chk("rmid_low",    n_low,          0);
    chk("rmid_done",   n_done,         0);
    chk("rmid_frames", frame_q.size(), 0);

    // tx_valid held high with tx_byte = cycle offset; accepts fall at
    // offsets 0, 2, 178 and 354, so bytes 0x00, 0x02, 0xB2, 0x62 go out
    clear_mon();
    tx_valid = 1'b1;
    for (int i = 0; i <= 354; i++) begin
      tx_byte = 8'(i);
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    wait_frames(4, 800);
    chk("cont_frame0",   qat(frame_q, 0), 11'b1_0_00000000_0);
    chk("cont_frame1",   qat(frame_q, 1), 11'b1_1_00000010_0);
    chk("cont_frame2",   qat(frame_q, 2), 11'b1_0_10110010_0);
    chk("cont_frame3",   qat(frame_q, 3), 11'b1_1_01100010_0);
    chk("cont_accepts",  acc_q.size(), 4);
    chk("cont_busy_len", qat(busy_run_q, 0), 704);
    chk("cont_ndone",    n_done, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter that feeds the receiver's rx_serial line, driven by the game logic (guesses and letters). It frames each byte as start(0), 8 data bits LSB-first, parity bit, stop(1). The parity bit equals the XOR of the data bits, which gives even parity over data plus parity and matches the receiver check. A one-deep holding register lets the producer queue the next byte while the current frame is shifting, so back-to-back frames leave no idle gap.

Parameters:
Clkperbaud, 1250, clk cycles per bit period (>=2); bit counter width is $clog2(Clkperbaud).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tx_byte  input  8  byte to send; sampled when tx_valid && tx_ready
tx_valid  input  1  producer has a byte on tx_byte
tx_ready  output  1  holding register empty; a byte can be accepted this cycle
tx_serial  output  1  serial line, idle high, registered
tx_busy  output  1  high while a frame is in START/DATA/PARITY/STOP
tx_done  output  1  one-cycle pulse on the last cycle of each stop bit

Behaviour:
- Reset: rst sampled high at a rising edge gives tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0. State is IDLE, holding register is empty, and counters are 0. Reset mid-frame aborts the frame immediately and discards any queued byte.
- Handshake: the holding register loads on tx_valid && tx_ready. tx_ready = !hold_full, registered. tx_ready deasserts the cycle after acceptance. tx_byte is ignored when tx_ready=0.
- Shift register: loads from the holding register when a frame starts, which empties the holding register. The parity bit is computed from the shift register at load time.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_serial=1. If hold_full, move to START next cycle and load the shift register.
- Latency: a byte accepted at edge k in IDLE with an empty holding register moves hold to shift at edge k+1. tx_serial=0 from edge k+2.
- START: drive 0 for Clkperbaud cycles, then go to DATA with bit_index=0.
- DATA: drive shift[bit_index] for Clkperbaud cycles per bit. Increment bit_index on each bit end. After bit 7, go to PARITY.
- PARITY: drive the parity bit for Clkperbaud cycles, then go to STOP.
- STOP: drive 1 for Clkperbaud cycles. tx_done=1 on the final cycle.
- End of STOP: if hold_full, go directly to START (shift register loads, next start bit begins the following cycle), otherwise go to IDLE.
- Frame length: exactly 11*Clkperbaud cycles of line time per byte.
- Simultaneous accept and frame start: if the hold register empties into the shift register in the same cycle that tx_valid is high, the new byte is not accepted that cycle, because tx_ready is registered low. It is accepted the next cycle.
- tx_busy: 1 in START/DATA/PARITY/STOP, 0 in IDLE.
- Counters: clk_count runs 0..Clkperbaud-1 and wraps to 0 on each bit boundary. bit_index is 3 bits and resets to 0 on entering DATA.
- tx_serial is glitch-free: driven from a flop only, never from combinational state decode.

Test Plan:
- Clkperbaud=16. Reset, then idle 50 cycles -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done never pulses.
- Send 0x41 (two ones) -> line reads 0, then 1,0,0,0,0,0,1,0, then parity 0, then stop 1; each bit lasts 16 cycles; tx_done pulses once at cycle 176 of the frame; uart_rx loopback gives rx_byte=0x41 with no error LEDs.
- Send 0x07 (three ones) -> parity bit 1; loopback uart_rx reports no parity error.
- Send 0xA5 then 0x3C, with the second byte offered on the cycle after the first is accepted and held until tx_ready -> 0x3C is accepted during the 0xA5 frame; its start bit follows the 0xA5 stop bit with zero idle cycles; tx_busy stays high for 352 cycles; two tx_done pulses occur.
- Assert rst for 1 cycle in DATA bit 3 of 0xFF with a byte queued -> tx_serial=1 next edge, tx_ready=1, tx_busy=0, the queued byte is dropped, and no tx_done pulse occurs.
- Hold tx_valid high continuously with a changing tx_byte -> only the values present on accept cycles are sent, in order, with none duplicated or skipped.
